tap_calib_ctrl: RTL and testbench

//   Receive-side input-delay calibration controller for the LVDS link.
//   - Sweeps the delay-tap counter from 0 to max and qualifies each tap against a training-pattern checker.
//   - Finds a passing eye window and loads its centre tap.
//   - Sits directly upstream of the tap counter: it drives that counter's inc/clr/set controls and reads back its count/max.

---
 rtl/tap_calib_ctrl_pkg.sv | 21 ++
 rtl/tap_calib_ctrl_if.sv | 50 +++++
 rtl/tap_calib_timer.sv | 27 ++
 rtl/tap_calib_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_tap_calib_ctrl.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/tap_calib_ctrl_pkg.sv
// tap_calib_ctrl_pkg: FSM state encoding and timer sizing helper shared by the tap calibration controller files.
package tap_calib_ctrl_pkg;

  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_CLR    = 4'd1;
  localparam logic [3:0] ST_SETTLE = 4'd2;
  localparam logic [3:0] ST_SAMPLE = 4'd3;
  localparam logic [3:0] ST_EVAL   = 4'd4;
  localparam logic [3:0] ST_STEP   = 4'd5;
  localparam logic [3:0] ST_CENTER = 4'd6;
  localparam logic [3:0] ST_DONE   = 4'd7;
  localparam logic [3:0] ST_FAIL   = 4'd8;

  // The timer is loaded with N-1, so clog2 of the longer phase is enough bits.
  function automatic int timer_width(input int settle_cycles, input int sample_cycles);
    int longest;
    longest = (settle_cycles > sample_cycles) ? settle_cycles : sample_cycles;
    return (longest <= 2) ? 1 : $clog2(longest);
  endfunction

endpackage

// File: rtl/tap_calib_ctrl_if.sv
// tap_calib_ctrl_if: start/status handshake, pattern checker input and tap-counter control bus
// of the tap calibration controller; master = controller side, slave = integrator side.
interface tap_calib_ctrl_if #(
  parameter int WIDTH = 5
);

  logic             i_start;
  logic             i_pattern_ok;
  logic [WIDTH-1:0] i_count;
  logic             i_max;
  logic             o_cnt_inc;
  logic             o_cnt_clr;
  logic             o_cnt_set;
  logic [WIDTH-1:0] o_cnt_set_val;
  logic             o_busy;
  logic             o_done;
  logic             o_fail;
  logic [WIDTH-1:0] o_center_tap;

  modport master (
    input  i_start,
    input  i_pattern_ok,
    input  i_count,
    input  i_max,
    output o_cnt_inc,
    output o_cnt_clr,
    output o_cnt_set,
    output o_cnt_set_val,
    output o_busy,
    output o_done,
    output o_fail,
    output o_center_tap
  );

  modport slave (
    output i_start,
    output i_pattern_ok,
    output i_count,
    output i_max,
    input  o_cnt_inc,
    input  o_cnt_clr,
    input  o_cnt_set,
    input  o_cnt_set_val,
    input  o_busy,
    input  o_done,
    input  o_fail,
    input  o_center_tap
  );

endinterface

// File: rtl/tap_calib_timer.sv
// tap_calib_timer: loadable down-counter with a zero flag, shared by the settle and sample phases.
module tap_calib_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/tap_calib_ctrl.sv
// tap_calib_ctrl: sweeps the input-delay tap counter, qualifies each tap and loads the centre of a passing eye.
// Build option TAP_CALIB_LONGEST_WIN_EN: full sweep, longest qualifying window wins (earliest on a tie).
module tap_calib_ctrl
  import tap_calib_ctrl_pkg::*;
#(
  parameter int WIDTH         = 5,
  parameter int SETTLE_CYCLES = 8,
  parameter int SAMPLE_CYCLES = 16,
  parameter int MIN_WIN       = 4
) (
  input  logic             i_clk,
  input  logic             i_arst_n,
  tap_calib_ctrl_if.master bus
);

  localparam int TW = timer_width(SETTLE_CYCLES, SAMPLE_CYCLES);

  logic [3:0]       state;
  logic [3:0]       state_nx;
  logic             tmr_load;
  logic             tmr_dec;
  logic             tmr_zero;
  logic [TW-1:0]    tmr_val;
  logic             pass_acc;

  logic             win_open;
  logic             win_open_nx;
  logic [WIDTH-1:0] win_start;
  logic [WIDTH-1:0] win_start_nx;
  logic             best_valid;
  logic             best_valid_nx;
  logic [WIDTH-1:0] best_start;
  logic [WIDTH-1:0] best_start_nx;
  logic [WIDTH-1:0] best_end;
  logic [WIDTH-1:0] best_end_nx;
`ifdef TAP_CALIB_LONGEST_WIN_EN
  logic [WIDTH:0]   best_len;
  logic [WIDTH:0]   best_len_nx;
`endif

  logic             close;
  logic [WIDTH-1:0] close_start;
  logic [WIDTH-1:0] close_end;
  logic [WIDTH:0]   close_len;
  logic             qualify;
  logic             record;
  logic [WIDTH:0]   center_sum;
  logic [WIDTH-1:0] center_nx;

  // Reloaded on every entry to SETTLE and again on the SETTLE->SAMPLE hand-over.
  assign tmr_load = (state == ST_CLR) || (state == ST_STEP) || ((state == ST_SETTLE) && tmr_zero);
  assign tmr_val  = (state == ST_SETTLE) ? TW'(SAMPLE_CYCLES - 1) : TW'(SETTLE_CYCLES - 1);
  assign tmr_dec  = (state == ST_SETTLE) || (state == ST_SAMPLE);

  tap_calib_timer #(
    .W(TW)
  ) u_timer (
    .clk     (i_clk),
    .rst_n   (i_arst_n),
    .load    (tmr_load),
    .load_val(tmr_val),
    .dec     (tmr_dec),
    .zero    (tmr_zero)
  );

  // Window tracking: lengths use one extra bit so a window spanning every tap does not wrap.
  always_comb begin
    win_open_nx   = win_open;
    win_start_nx  = win_start;
    best_valid_nx = best_valid;
    best_start_nx = best_start;
    best_end_nx   = best_end;
`ifdef TAP_CALIB_LONGEST_WIN_EN
    best_len_nx   = best_len;
`endif
    close         = 1'b0;
    close_start   = win_start;
    close_end     = bus.i_count;

    if (state == ST_CLR) begin
      win_open_nx   = 1'b0;
      win_start_nx  = '0;
      best_valid_nx = 1'b0;
      best_start_nx = '0;
      best_end_nx   = '0;
`ifdef TAP_CALIB_LONGEST_WIN_EN
      best_len_nx   = '0;
`endif
    end else if (state == ST_EVAL) begin
      if (!pass_acc && win_open) begin
        close       = 1'b1;
        close_end   = bus.i_count - WIDTH'(1);
        win_open_nx = 1'b0;
      end else if (pass_acc && bus.i_max) begin
        close       = 1'b1;
        close_start = win_open ? win_start : bus.i_count;
        win_open_nx = 1'b0;
      end else if (pass_acc && !win_open) begin
        win_open_nx  = 1'b1;
        win_start_nx = bus.i_count;
      end
    end

    close_len = {1'b0, close_end} - {1'b0, close_start} + (WIDTH+1)'(1);
    qualify   = close && (close_len >= (WIDTH+1)'(MIN_WIN));
`ifdef TAP_CALIB_LONGEST_WIN_EN
    record    = qualify && (!best_valid || (close_len > best_len));
`else
    record    = qualify && !best_valid;
`endif

    if (record) begin
      best_valid_nx = 1'b1;
      best_start_nx = close_start;
      best_end_nx   = close_end;
`ifdef TAP_CALIB_LONGEST_WIN_EN
      best_len_nx   = close_len;
`endif
    end

    center_sum = {1'b0, best_start_nx} + {1'b0, best_end_nx};
    center_nx  = center_sum[WIDTH:1];
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE, ST_DONE, ST_FAIL: if (bus.i_start) state_nx = ST_CLR;
      ST_CLR:    state_nx = ST_SETTLE;
      ST_SETTLE: if (tmr_zero) state_nx = ST_SAMPLE;
      ST_SAMPLE: if (tmr_zero) state_nx = ST_EVAL;
`ifdef TAP_CALIB_LONGEST_WIN_EN
      ST_EVAL:   state_nx = bus.i_max ? ST_CENTER : ST_STEP;
`else
      ST_EVAL:   state_nx = (record || bus.i_max) ? ST_CENTER : ST_STEP;
`endif
      ST_STEP:   state_nx = ST_SETTLE;
      ST_CENTER: state_nx = best_valid ? ST_DONE : ST_FAIL;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so each strobe is high exactly in the state that owns it.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state             <= ST_IDLE;
      pass_acc          <= 1'b0;
      win_open          <= 1'b0;
      win_start         <= '0;
      best_valid        <= 1'b0;
      best_start        <= '0;
      best_end          <= '0;
`ifdef TAP_CALIB_LONGEST_WIN_EN
      best_len          <= '0;
`endif
      bus.o_cnt_inc     <= 1'b0;
      bus.o_cnt_clr     <= 1'b0;
      bus.o_cnt_set     <= 1'b0;
      bus.o_cnt_set_val <= '0;
      bus.o_busy        <= 1'b0;
      bus.o_done        <= 1'b0;
      bus.o_fail        <= 1'b0;
      bus.o_center_tap  <= '0;
    end else begin
      state      <= state_nx;
      win_open   <= win_open_nx;
      win_start  <= win_start_nx;
      best_valid <= best_valid_nx;
      best_start <= best_start_nx;
      best_end   <= best_end_nx;
`ifdef TAP_CALIB_LONGEST_WIN_EN
      best_len   <= best_len_nx;
`endif

      if (state == ST_SETTLE) begin
        pass_acc <= 1'b1;
      end else if (state == ST_SAMPLE) begin
        pass_acc <= pass_acc & bus.i_pattern_ok;
      end

      bus.o_cnt_inc <= (state_nx == ST_STEP);
      bus.o_cnt_clr <= (state_nx == ST_CLR) || ((state_nx == ST_CENTER) && !best_valid_nx);
      bus.o_cnt_set <= (state_nx == ST_CENTER) && best_valid_nx;
      if ((state_nx == ST_CENTER) && best_valid_nx) begin
        bus.o_cnt_set_val <= center_nx;
      end
      if (state == ST_CENTER) begin
        bus.o_center_tap <= best_valid ? bus.o_cnt_set_val : '0;
      end

      bus.o_busy <= (state_nx inside {ST_CLR, ST_SETTLE, ST_SAMPLE, ST_EVAL, ST_STEP, ST_CENTER});
      bus.o_done <= (state_nx == ST_DONE);
      bus.o_fail <= (state_nx == ST_FAIL);
    end
  end

endmodule

// File: tb/tb_tap_calib_ctrl.sv
// tb_tap_calib_ctrl: scoreboard bench for tap_calib_ctrl driving a behavioural tap-counter model.
// Honours TAP_CALIB_LONGEST_WIN_EN when the design is built with it.
module tb_tap_calib_ctrl;

  localparam int WIDTH      = 5;
  localparam int SETTLE     = 4;
  localparam int SAMPLE     = 8;
  localparam int MIN_WIN    = 4;
  localparam int TAP_CYCLES = SETTLE + SAMPLE + 2;
`ifdef TAP_CALIB_LONGEST_WIN_EN
  localparam bit LONGEST = 1'b1;
`else
  localparam bit LONGEST = 1'b0;
`endif

  typedef struct {
    string name;
    bit    done;
    int    center;
    int    last_tap;
  } exp_t;

  logic clk    = 1'b0;
  logic arst_n = 1'b1;

  tap_calib_ctrl_if #(.WIDTH(WIDTH)) bus ();

  tap_calib_ctrl #(
    .WIDTH        (WIDTH),
    .SETTLE_CYCLES(SETTLE),
    .SAMPLE_CYCLES(SAMPLE),
    .MIN_WIN      (MIN_WIN)
  ) dut (
    .i_clk   (clk),
    .i_arst_n(arst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  logic [4:0]  tap_count  = '0;
  int          tap_cyc    = 0;
  logic [31:0] ok_mask    = '0;
  bit          glitch_en  = 1'b0;
  logic [4:0]  glitch_tap = '0;

  exp_t exp_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   mon_busy     = 0;
  int   mon_max      = 0;
  int   mon_viol     = 0;
  int   mon_set_val  = 0;
  logic prev_inc = 1'b0, prev_clr = 1'b0, prev_set = 1'b0;

  // Tap counter model; it has no reset so a controller reset must leave it untouched.
  always @(posedge clk) begin
    if (bus.o_cnt_clr) begin
      tap_count <= '0;
      tap_cyc   <= 0;
    end else if (bus.o_cnt_set) begin
      tap_count <= bus.o_cnt_set_val;
      tap_cyc   <= 0;
    end else if (bus.o_cnt_inc) begin
      tap_count <= tap_count + 5'd1;
      tap_cyc   <= 0;
    end else if (tap_cyc < 1000) begin
      tap_cyc   <= tap_cyc + 1;
    end
  end

  assign bus.i_count      = tap_count;
  assign bus.i_max        = (tap_count == 5'd31);
  assign bus.i_pattern_ok = ok_mask[tap_count] && !(glitch_en && (tap_count == glitch_tap) && (tap_cyc == 7));

  always @(negedge clk) begin
    if (bus.o_busy) mon_busy++;
    if (bus.o_busy && !bus.o_cnt_clr && (int'(tap_count) > mon_max)) mon_max = int'(tap_count);
    if ((int'(bus.o_cnt_inc) + int'(bus.o_cnt_clr) + int'(bus.o_cnt_set)) > 1) mon_viol++;
    if ((bus.o_cnt_inc && prev_inc) || (bus.o_cnt_clr && prev_clr) || (bus.o_cnt_set && prev_set)) mon_viol++;
    if (bus.o_cnt_inc && (tap_count == 5'd31)) mon_viol++;
    if (bus.o_cnt_set) mon_set_val = int'(bus.o_cnt_set_val);
    prev_inc = bus.o_cnt_inc;
    prev_clr = bus.o_cnt_clr;
    prev_set = bus.o_cnt_set;
  end

  function automatic logic [31:0] mk(input int lo, input int hi);
    logic [31:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    #1 bus.i_start = 1'b1;
    @(posedge clk);
    #1 bus.i_start = 1'b0;
  endtask

  task automatic run_case(input string name, input logic [31:0] mask, input bit g_en, input int g_tap,
                          input bit exp_done, input int exp_center, input int early_last, input int poke_at);
    exp_t e;
    bit   finished;
    ok_mask    = mask;
    glitch_en  = g_en;
    glitch_tap = 5'(g_tap);
    e.name     = name;
    e.done     = exp_done;
    e.center   = exp_done ? exp_center : 0;
    e.last_tap = (LONGEST || !exp_done) ? 31 : early_last;
    exp_q.push_back(e);
    mon_busy    = 0;
    mon_max     = 0;
    mon_viol    = 0;
    mon_set_val = 0;

    applyStimulus();
    checkOutput({name, ".start_clr"}, 32'(bus.o_cnt_clr), 1);
    checkOutput({name, ".start_busy"}, 32'(bus.o_busy), 1);
    checkOutput({name, ".start_status"}, 32'({bus.o_done, bus.o_fail}), 0);

    finished = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      if (c == poke_at) bus.i_start = 1'b1;
      @(posedge clk);
      #1 bus.i_start = 1'b0;
      if (bus.o_done || bus.o_fail) begin
        finished = 1'b1;
        break;
      end
    end
    checkOutput({name, ".finished"}, 32'(finished), 1);

    e = exp_q.pop_front();
    checkOutput({e.name, ".done"}, 32'(bus.o_done), 32'(e.done));
    checkOutput({e.name, ".fail"}, 32'(bus.o_fail), 32'(!e.done));
    checkOutput({e.name, ".busy_end"}, 32'(bus.o_busy), 0);
    checkOutput({e.name, ".center_tap"}, 32'(bus.o_center_tap), e.center);
    checkOutput({e.name, ".set_val"}, mon_set_val, e.center);
    checkOutput({e.name, ".counter"}, 32'(tap_count), e.center);
    checkOutput({e.name, ".last_tap"}, mon_max, e.last_tap);
    checkOutput({e.name, ".busy_cycles"}, mon_busy, (e.last_tap + 1) * TAP_CYCLES + 1);
    checkOutput({e.name, ".strobe_rules"}, mon_viol, 0);
  endtask

  initial begin
    bit found;
    bus.i_start = 1'b0;
    #0 arst_n = 1'b0;
    #1;
    checkOutput("reset.outputs", 32'({bus.o_busy, bus.o_done, bus.o_fail, bus.o_cnt_inc, bus.o_cnt_clr,
                                      bus.o_cnt_set, bus.o_cnt_set_val, bus.o_center_tap}), 0);
    repeat (3) @(posedge clk);
    @(negedge clk) arst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 checkOutput("reset.idle", 32'({bus.o_busy, bus.o_cnt_clr, bus.o_done, bus.o_fail}), 0);

    run_case("t1_win10_17", mk(10, 17), 1'b0, 0, 1'b1, 13, 18, 50);
    run_case("t2_all_fail", '0, 1'b0, 0, 1'b0, 0, 31, -1);
    run_case("t3_two_wins", mk(3, 8) | mk(15, 28), 1'b0, 0, 1'b1, LONGEST ? 21 : 5, 9, -1);
    run_case("t4_glitch12", mk(10, 17), 1'b1, 12, 1'b1, 15, 18, -1);
    run_case("t5_win20_31", mk(20, 31), 1'b0, 0, 1'b1, 25, 31, -1);
    run_case("t5_win0_31", mk(0, 31), 1'b0, 0, 1'b1, 15, 31, -1);

    ok_mask   = '0;
    glitch_en = 1'b0;
    applyStimulus();
    found = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      #1;
      if ((tap_count == 5'd7) && (tap_cyc == 5)) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("rst.reach_tap7", 32'(found), 1);
    checkOutput("rst.busy_before", 32'(bus.o_busy), 1);
    @(negedge clk);
    #2 arst_n = 1'b0;
    #1;
    checkOutput("rst.outputs", 32'({bus.o_busy, bus.o_done, bus.o_fail, bus.o_cnt_inc, bus.o_cnt_clr,
                                    bus.o_cnt_set, bus.o_cnt_set_val, bus.o_center_tap}), 0);
    repeat (3) @(posedge clk);
    #1 checkOutput("rst.counter_held", 32'(tap_count), 7);
    @(negedge clk) arst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1 checkOutput("rst.idle", 32'({bus.o_busy, bus.o_cnt_clr, bus.o_done, bus.o_fail}), 0);
    checkOutput("rst.counter_idle", 32'(tap_count), 7);

    run_case("t6_recover", mk(10, 17), 1'b0, 0, 1'b1, 13, 18, -1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
